rv_thread_sched: RTL

RV_THREAD_SCHED -- requirements
Module: rv_thread_sched

---
 rtl/rv_mt_pkg.sv | 21 ++
 rtl/rv_thread_sched_if.sv | 53 +++++
 rtl/rv_alu_v.sv | 55 +++++
 rtl/rv_rr_arbiter.sv | 27 ++
 rtl/rv_thread_sched.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/rv_mt_pkg.sv
// rtl/rv_mt_pkg.sv - shared parameters, FSM state type and RV opcode constants for the thread scheduler
package rv_mt_pkg;

    localparam int NTHREADS = 4;
    localparam int XLEN     = 32;
    localparam int TID_W    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } sched_state_t;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

endpackage

// File: rtl/rv_thread_sched_if.sv
// rtl/rv_thread_sched_if.sv - per-thread request, shared ALU and response bundle of the scheduler
interface rv_thread_sched_if #(
    parameter int NTHREADS = rv_mt_pkg::NTHREADS,
    parameter int XLEN     = rv_mt_pkg::XLEN
);
    localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

    logic [NTHREADS-1:0]      thr_en;
    logic [NTHREADS-1:0]      req_valid;
    logic [NTHREADS-1:0]      req_ready;
    logic [NTHREADS*7-1:0]    req_opcode;
    logic [NTHREADS*3-1:0]    req_funct3;
    logic [NTHREADS*7-1:0]    req_funct7;
    logic [NTHREADS*XLEN-1:0] req_op1;
    logic [NTHREADS*XLEN-1:0] req_op2;

    logic [6:0]               alu_opcode;
    logic [2:0]               alu_funct3;
    logic [6:0]               alu_funct7;
    logic [XLEN-1:0]          alu_op1;
    logic [XLEN-1:0]          alu_op2;
    logic [XLEN-1:0]          alu_rez;

    logic                     rsp_valid;
    logic [TW-1:0]            rsp_tid;
    logic [XLEN-1:0]          rsp_data;

    logic                     halt_req;
    logic                     halted;

    // scheduler side
    modport slave (
        input  thr_en, req_valid, req_opcode, req_funct3, req_funct7, req_op1, req_op2,
        output req_ready,
        output alu_opcode, alu_funct3, alu_funct7, alu_op1, alu_op2,
        input  alu_rez,
        output rsp_valid, rsp_tid, rsp_data,
        input  halt_req,
        output halted
    );

    // thread / ALU side
    modport master (
        output thr_en, req_valid, req_opcode, req_funct3, req_funct7, req_op1, req_op2,
        input  req_ready,
        input  alu_opcode, alu_funct3, alu_funct7, alu_op1, alu_op2,
        output alu_rez,
        input  rsp_valid, rsp_tid, rsp_data,
        output halt_req,
        input  halted
    );

endinterface

// File: rtl/rv_alu_v.sv
// rtl/rv_alu_v.sv - combinational RV integer ALU shared by all hardware threads
module rv_alu_v import rv_mt_pkg::*; #(
    parameter int W = XLEN
) (
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic [W-1:0] rez
);

    localparam int SHW = (W > 1) ? $clog2(W) : 1;

    logic [SHW-1:0] shamt;
    logic           alt;

    assign shamt = op2[SHW-1:0];
    assign alt   = (funct7 == 7'h20);

    // arithmetic/logic result selected by opcode and funct fields
    always_comb begin
        rez = '0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (funct3)
                    3'd0: rez = (opcode == OPC_OP && alt) ? (op1 - op2) : (op1 + op2);
                    3'd1: rez = op1 << shamt;
                    3'd2: rez = {{(W-1){1'b0}}, ($signed(op1) < $signed(op2))};
                    3'd3: rez = {{(W-1){1'b0}}, (op1 < op2)};
                    3'd4: rez = op1 ^ op2;
                    3'd5: rez = alt ? W'($signed(op1) >>> shamt) : (op1 >> shamt);
                    3'd6: rez = op1 | op2;
                    default: rez = op1 & op2;
                endcase
            end
            OPC_LUI:  rez = op2;
            OPC_LOAD: rez = op1 + op2;
            OPC_JAL:  rez = op1 + W'(4);
            OPC_BRANCH: begin
                case (funct3)
                    3'd0: rez = {{(W-1){1'b0}}, (op1 == op2)};
                    3'd1: rez = {{(W-1){1'b0}}, (op1 != op2)};
                    3'd4: rez = {{(W-1){1'b0}}, ($signed(op1) < $signed(op2))};
                    3'd5: rez = {{(W-1){1'b0}}, ($signed(op1) >= $signed(op2))};
                    3'd6: rez = {{(W-1){1'b0}}, (op1 < op2)};
                    3'd7: rez = {{(W-1){1'b0}}, (op1 >= op2)};
                    default: rez = '0;
                endcase
            end
            default: rez = '0;
        endcase
    end

endmodule

// File: rtl/rv_rr_arbiter.sv
// rtl/rv_rr_arbiter.sv - round-robin one-hot grant starting after the last granted thread
module rv_rr_arbiter import rv_mt_pkg::*; #(
    parameter int NT = NTHREADS,
    parameter int TW = TID_W
) (
    input  logic [NT-1:0] eligible,
    input  logic [TW-1:0] last_grant,
    output logic [NT-1:0] grant
);

    logic found;

    // walk offsets 1..NT from last_grant; first eligible thread wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NT; k++) begin
            for (int j = 0; j < NT; j++) begin
                if (!found && eligible[j] && (((int'(last_grant) + k) % NT) == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rv_thread_sched.sv
// rtl/rv_thread_sched.sv - round-robin issue of per-thread ALU operations onto one shared ALU
module rv_thread_sched #(
    parameter int NTHREADS = rv_mt_pkg::NTHREADS,
    parameter int XLEN     = rv_mt_pkg::XLEN
) (
    input  logic           clk,
    input  logic           rst_n,
    rv_thread_sched_if.slave bus
);

    localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
    localparam logic [TW-1:0] LAST_TID = TW'(NTHREADS - 1);

    rv_mt_pkg::sched_state_t state;

    logic [NTHREADS-1:0] busy;
    logic [NTHREADS-1:0] busy_nxt;
    logic [NTHREADS-1:0] eligible;
    logic [NTHREADS-1:0] grant;
    logic                any_grant;
    logic [TW-1:0]       last_grant;
    logic [TW-1:0]       win_tid;
    logic                s1_valid;
    logic [TW-1:0]       s1_tid;
    logic                halted_q;

    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [XLEN-1:0]     w_op1;
    logic [XLEN-1:0]     w_op2;

    logic [6:0]          alu_opcode_q;
    logic [2:0]          alu_funct3_q;
    logic [6:0]          alu_funct7_q;
    logic [XLEN-1:0]     alu_op1_q;
    logic [XLEN-1:0]     alu_op2_q;

    logic                rsp_valid_q;
    logic [TW-1:0]       rsp_tid_q;
    logic [XLEN-1:0]     rsp_data_q;

    // a thread may issue only while running, enabled and with nothing outstanding
    assign eligible = bus.req_valid & bus.thr_en & ~busy
                    & {NTHREADS{state == rv_mt_pkg::ST_RUN}};

    rv_rr_arbiter #(
        .NT (NTHREADS),
        .TW (TW)
    ) u_arb (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign any_grant     = |grant;
    assign bus.req_ready = rst_n ? grant : '0;

    // steer the winning thread's fields toward the ALU drive registers
    always_comb begin
        win_tid  = '0;
        w_opcode = '0;
        w_funct3 = '0;
        w_funct7 = '0;
        w_op1    = '0;
        w_op2    = '0;
        for (int j = 0; j < NTHREADS; j++) begin
            if (grant[j]) begin
                win_tid  = TW'(j);
                w_opcode = bus.req_opcode[j*7 +: 7];
                w_funct3 = bus.req_funct3[j*3 +: 3];
                w_funct7 = bus.req_funct7[j*7 +: 7];
                w_op1    = bus.req_op1[j*XLEN +: XLEN];
                w_op2    = bus.req_op2[j*XLEN +: XLEN];
            end
        end
    end

    // retiring thread frees its slot, the new winner claims one
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NTHREADS; j++) begin
            if (s1_valid && (s1_tid == TW'(j))) begin
                busy_nxt[j] = 1'b0;
            end
        end
        busy_nxt = busy_nxt | grant;
    end

    // issue/response pipeline and RUN/DRAIN/HALTED control with registered halted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= rv_mt_pkg::ST_RUN;
            halted_q     <= 1'b0;
            busy         <= '0;
            last_grant   <= LAST_TID;
            s1_valid     <= 1'b0;
            s1_tid       <= '0;
            alu_opcode_q <= '0;
            alu_funct3_q <= '0;
            alu_funct7_q <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_tid_q    <= '0;
            rsp_data_q   <= '0;
        end else begin
            busy        <= busy_nxt;
            s1_valid    <= any_grant;
            rsp_valid_q <= s1_valid;
            if (s1_valid) begin
                rsp_tid_q  <= s1_tid;
                rsp_data_q <= bus.alu_rez;
            end
            if (any_grant) begin
                alu_opcode_q <= w_opcode;
                alu_funct3_q <= w_funct3;
                alu_funct7_q <= w_funct7;
                alu_op1_q    <= w_op1;
                alu_op2_q    <= w_op2;
                last_grant   <= win_tid;
                s1_tid       <= win_tid;
            end
            case (state)
                rv_mt_pkg::ST_RUN: begin
                    if (bus.halt_req) begin
                        state    <= rv_mt_pkg::ST_DRAIN;
                        halted_q <= 1'b0;
                    end
                end
                rv_mt_pkg::ST_DRAIN: begin
                    if (!bus.halt_req) begin
                        state    <= rv_mt_pkg::ST_RUN;
                        halted_q <= 1'b0;
                    end else if (!s1_valid && (busy == '0)) begin
                        state    <= rv_mt_pkg::ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                rv_mt_pkg::ST_HALTED: begin
                    if (!bus.halt_req) begin
                        state    <= rv_mt_pkg::ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= rv_mt_pkg::ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_funct3 = alu_funct3_q;
    assign bus.alu_funct7 = alu_funct7_q;
    assign bus.alu_op1    = alu_op1_q;
    assign bus.alu_op2    = alu_op2_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_tid    = rsp_tid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.halted     = halted_q;

endmodule
